// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data request/response channel.
// Byte-writable word RAM behind a ready/valid handshake with programmable latency.
module data_mem_responder #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned REQ_DELAY  = 0,
    parameter int unsigned RESP_DELAY = 1,
    parameter bit          RAND_EN    = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Mem_Addr,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready,
    output logic [31:0] Rd_Count,
    output logic [31:0] Wr_Count
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_RQD  = 5'b00010,
        S_ACK  = 5'b00100,
        S_RSD  = 5'b01000,
        S_RSP  = 5'b10000
    } state_t;

    state_t       state_reg;
    logic         ready_reg;
    logic         valid_reg;
    logic         op_write_reg;
    logic [4:0]   dly_cnt_reg;
    logic [3:0]   lfsr_reg;
    logic [3:0]   lfsr_next;
    logic [31:0]  rd_count_reg;
    logic [31:0]  wr_count_reg;
    logic [4:0]   req_dly_next;
    logic [4:0]   resp_dly_next;
    logic [ADDR_W-1:0] word_idx;
    logic         wr_en;
    logic         rd_en;
    logic [3:0][7:0] read_data_bytes;
    logic         unused_addr_bits;

    assign word_idx         = Mem_Addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{Mem_Addr[31:ADDR_W+2], Mem_Addr[1:0]};

    // x^4 + x^3 + 1, Fibonacci form
    assign lfsr_next = {lfsr_reg[2:0], lfsr_reg[3] ^ lfsr_reg[2]};

    always_comb begin
        req_dly_next  = 5'(REQ_DELAY);
        resp_dly_next = 5'(RESP_DELAY);
        if (RAND_EN) begin
            req_dly_next  = req_dly_next  + {3'b000, lfsr_reg[1:0]};
            resp_dly_next = resp_dly_next + {3'b000, lfsr_reg[1:0]};
        end
    end

    // RAM access only happens on the handshake edge; a reset on that edge cancels it.
    assign wr_en = rst_n && (state_reg == S_ACK) &&  op_write_reg;
    assign rd_en = rst_n && (state_reg == S_ACK) && !op_write_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            ready_reg    <= 1'b0;
            valid_reg    <= 1'b0;
            op_write_reg <= 1'b0;
            dly_cnt_reg  <= '0;
            lfsr_reg     <= 4'b1001;
            rd_count_reg <= '0;
            wr_count_reg <= '0;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (MemWrite || MemRead) begin
                        op_write_reg <= MemWrite;
                        dly_cnt_reg  <= req_dly_next;
                        if (req_dly_next == 5'd0) begin
                            state_reg <= S_ACK;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg <= S_RQD;
                        end
                    end
                end
                S_RQD: begin
                    dly_cnt_reg <= dly_cnt_reg - 5'd1;
                    if (dly_cnt_reg == 5'd1) begin
                        state_reg <= S_ACK;
                        ready_reg <= 1'b1;
                    end
                end
                S_ACK: begin
                    ready_reg <= 1'b0;
                    if (RAND_EN) begin
                        lfsr_reg <= lfsr_next;
                    end
                    if (op_write_reg) begin
                        wr_count_reg <= wr_count_reg + 32'd1;
                        state_reg    <= S_IDLE;
                    end else begin
                        dly_cnt_reg <= resp_dly_next;
                        if (resp_dly_next == 5'd0) begin
                            state_reg <= S_RSP;
                            valid_reg <= 1'b1;
                        end else begin
                            state_reg <= S_RSD;
                        end
                    end
                end
                S_RSD: begin
                    dly_cnt_reg <= dly_cnt_reg - 5'd1;
                    if (dly_cnt_reg == 5'd1) begin
                        state_reg <= S_RSP;
                        valid_reg <= 1'b1;
                    end
                end
                S_RSP: begin
                    if (Read_data_Ready) begin
                        valid_reg    <= 1'b0;
                        rd_count_reg <= rd_count_reg + 32'd1;
                        state_reg    <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    ready_reg <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // One byte-wide RAM per lane so each strobe maps to its own write enable.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q_reg;

            always_ff @(posedge clk) begin
                if (wr_en && Write_strb[gi]) begin
                    lane_mem[word_idx] <= Write_data[8*gi +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lane_q_reg <= '0;
                end else if (rd_en) begin
                    lane_q_reg <= lane_mem[word_idx];
                end
            end

            assign read_data_bytes[gi] = lane_q_reg;
        end
    endgenerate

    assign Mem_Req_Ready   = ready_reg;
    assign Read_data_Valid = valid_reg;
    assign Read_data       = read_data_bytes;
    assign Rd_Count        = rd_count_reg;
    assign Wr_Count        = wr_count_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: unit 0 runs REQ_DELAY=0/RESP_DELAY=1, unit 1 runs REQ_DELAY=3/RESP_DELAY=2.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n [2];
    logic [31:0] ma    [2];
    logic        mw    [2];
    logic [31:0] wd    [2];
    logic [3:0]  ws    [2];
    logic        mr    [2];
    logic        rdy   [2];
    logic [31:0] rdat  [2];
    logic        vld   [2];
    logic        rr    [2];
    logic [31:0] rdc   [2];
    logic [31:0] wrc   [2];

    int n_checks = 0;
    int n_errors = 0;

    data_mem_responder #(.ADDR_W(10), .REQ_DELAY(0), .RESP_DELAY(1), .RAND_EN(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .Mem_Addr(ma[0]), .MemWrite(mw[0]), .Write_data(wd[0]),
        .Write_strb(ws[0]), .MemRead(mr[0]), .Mem_Req_Ready(rdy[0]), .Read_data(rdat[0]),
        .Read_data_Valid(vld[0]), .Read_data_Ready(rr[0]), .Rd_Count(rdc[0]), .Wr_Count(wrc[0])
    );

    data_mem_responder #(.ADDR_W(10), .REQ_DELAY(3), .RESP_DELAY(2), .RAND_EN(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .Mem_Addr(ma[1]), .MemWrite(mw[1]), .Write_data(wd[1]),
        .Write_strb(ws[1]), .MemRead(mr[1]), .Mem_Req_Ready(rdy[1]), .Read_data(rdat[1]),
        .Read_data_Valid(vld[1]), .Read_data_Ready(rr[1]), .Rd_Count(rdc[1]), .Wr_Count(wrc[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int u, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input bit also_read, input int qd,
                            input logic [31:0] exp_wrc, input logic [31:0] exp_rdc);
        mw[u] = 1'b1; mr[u] = also_read; ma[u] = a; wd[u] = d; ws[u] = s;
        tick;
        for (int i = 0; i < qd; i++) begin
            check($sformatf("u%0d wr rdy_low[%0d]", u, i), 32'(rdy[u]), 32'd0);
            tick;
        end
        check($sformatf("u%0d wr rdy_high", u), 32'(rdy[u]), 32'd1);
        tick;
        mw[u] = 1'b0; mr[u] = 1'b0;
        check($sformatf("u%0d wr rdy_drop", u), 32'(rdy[u]), 32'd0);
        check($sformatf("u%0d wr_count", u), wrc[u], exp_wrc);
        check($sformatf("u%0d wr no_valid", u), 32'(vld[u]), 32'd0);
        check($sformatf("u%0d wr rd_count", u), rdc[u], exp_rdc);
    endtask

    task automatic do_read(input int u, input logic [31:0] a, input int qd, input int rd,
                           input logic [31:0] exp_data, input int hold, input logic [31:0] exp_rdc);
        mr[u] = 1'b1; ma[u] = a; rr[u] = 1'b0;
        tick;
        for (int i = 0; i < qd; i++) begin
            check($sformatf("u%0d rd rdy_low[%0d]", u, i), 32'(rdy[u]), 32'd0);
            tick;
        end
        check($sformatf("u%0d rd rdy_high", u), 32'(rdy[u]), 32'd1);
        tick;
        mr[u] = 1'b0;
        check($sformatf("u%0d rd rdy_drop", u), 32'(rdy[u]), 32'd0);
        for (int i = 0; i < rd; i++) begin
            check($sformatf("u%0d rd valid_low[%0d]", u, i), 32'(vld[u]), 32'd0);
            tick;
        end
        check($sformatf("u%0d rd valid_high", u), 32'(vld[u]), 32'd1);
        check($sformatf("u%0d rd data", u), rdat[u], exp_data);
        for (int i = 0; i < hold; i++) begin
            tick;
            check($sformatf("u%0d rd hold_valid[%0d]", u, i), 32'(vld[u]), 32'd1);
            check($sformatf("u%0d rd hold_data[%0d]", u, i), rdat[u], exp_data);
        end
        rr[u] = 1'b1;
        tick;
        rr[u] = 1'b0;
        check($sformatf("u%0d rd valid_drop", u), 32'(vld[u]), 32'd0);
        check($sformatf("u%0d rd_count", u), rdc[u], exp_rdc);
        check($sformatf("u%0d rd data_kept", u), rdat[u], exp_data);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; ma[u] = '0; mw[u] = 1'b0; wd[u] = '0;
            ws[u] = '0; mr[u] = 1'b0; rr[u] = 1'b0;
        end
        tick;
        tick;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d reset ready", u), 32'(rdy[u]), 32'd0);
            check($sformatf("u%0d reset valid", u), 32'(vld[u]), 32'd0);
            check($sformatf("u%0d reset data", u), rdat[u], 32'd0);
            check($sformatf("u%0d reset rd_count", u), rdc[u], 32'd0);
            check($sformatf("u%0d reset wr_count", u), wrc[u], 32'd0);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // Unit 0: write, read-back, byte strobe, low-bit aliasing, back-pressure
        do_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, 32'd1, 32'd0);
        do_read (0, 32'h10, 0, 1, 32'hDEADBEEF, 0, 32'd1);
        do_write(0, 32'h10, 32'h11223344, 4'h2, 1'b0, 0, 32'd2, 32'd1);
        do_read (0, 32'h13, 0, 1, 32'hDEAD33EF, 5, 32'd2);
        do_write(0, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, 0, 32'd3, 32'd2);
        do_read (0, 32'h10, 0, 1, 32'hDEAD33EF, 0, 32'd3);

        // Simultaneous read+write is a write; 4*1024+8 aliases to 8
        do_write(0, 32'h1008, 32'hCAFEF00D, 4'hF, 1'b1, 0, 32'd4, 32'd3);
        tick;
        check("u0 both no_valid", 32'(vld[0]), 32'd0);
        check("u0 both rd_count", rdc[0], 32'd3);
        do_read (0, 32'h8, 0, 1, 32'hCAFEF00D, 0, 32'd4);

        // Read_data_Ready while idle changes nothing
        rr[0] = 1'b1;
        tick;
        tick;
        rr[0] = 1'b0;
        check("u0 stray_ready rd_count", rdc[0], 32'd4);
        check("u0 stray_ready valid", 32'(vld[0]), 32'd0);

        // Reset while the read is in its response delay
        mr[0] = 1'b1; ma[0] = 32'h10;
        tick;
        tick;
        mr[0] = 1'b0;
        rst_n[0] = 1'b0;
        tick;
        rst_n[0] = 1'b1;
        check("u0 midrd valid", 32'(vld[0]), 32'd0);
        check("u0 midrd rd_count", rdc[0], 32'd0);
        check("u0 midrd wr_count", wrc[0], 32'd0);
        check("u0 midrd data", rdat[0], 32'd0);
        tick;
        check("u0 midrd valid_after", 32'(vld[0]), 32'd0);
        do_read (0, 32'h10, 0, 1, 32'hDEAD33EF, 0, 32'd1);

        // Unit 1: request and response delays
        do_write(1, 32'h20, 32'h0BADF00D, 4'hF, 1'b0, 3, 32'd1, 32'd0);
        do_read (1, 32'h20, 3, 2, 32'h0BADF00D, 0, 32'd1);

        // Reset before the ACK edge abandons the write
        mw[1] = 1'b1; ma[1] = 32'h20; wd[1] = 32'h12345678; ws[1] = 4'hF;
        tick;
        tick;
        tick;
        rst_n[1] = 1'b0;
        tick;
        mw[1] = 1'b0;
        rst_n[1] = 1'b1;
        check("u1 abort rdy", 32'(rdy[1]), 32'd0);
        check("u1 abort wr_count", wrc[1], 32'd0);
        tick;
        check("u1 abort rdy_after", 32'(rdy[1]), 32'd0);
        do_read (1, 32'h20, 3, 2, 32'h0BADF00D, 2, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
